// File: rtl/vid_axis_pkg.sv
// vid_axis_pkg: shared types and widths for the video-to-AXI4-Stream packer
package vid_axis_pkg;
   localparam int PIX_W   = 24;
   localparam int ENTRY_W = 26;
   localparam int TDATA_W = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, ACTIVE = 2'd2} cap_state_t;
   typedef struct packed {
      logic             sof;
      logic             last;
      logic [PIX_W-1:0] pix;
   } entry_t;
endpackage

// File: rtl/vid_to_axis_packer_if.sv
// vid_to_axis_packer_if: AXI4-Stream pixel bus with master/slave views
interface vid_to_axis_packer_if;
   import vid_axis_pkg::*;
   logic [TDATA_W-1:0] tdata;
   logic               tvalid;
   logic               tready;
   logic               tlast;
   logic               tuser;
   modport master(output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave(input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/vid_to_axis_packer_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with registered occupancy and flags
module sync_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             drop
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [AW:0]      cnt, cnt_n;
   logic             full, wr, rd;
   assign wr    = push & ~full;
   assign rd    = pop & ~empty;
   assign drop  = push & full;
   assign cnt_n = cnt + (AW+1)'(wr) - (AW+1)'(rd);
   assign dout  = empty ? '0 : mem[rp];
   // pointers, occupancy and flags; full/empty follow the registered count
   always_ff @(posedge clk) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wp    <= wr ? wp + AW'(1) : wp;
         rp    <= rd ? rp + AW'(1) : rp;
         cnt   <= cnt_n;
         full  <= cnt_n == (AW+1)'(DEPTH);
         empty <= cnt_n == '0;
      end
   end
   // storage array, left unreset since empty masks the read port
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= din;
   end
endmodule

// File: rtl/vid_to_axis_packer.sv
// vid_to_axis_packer: captures whole gated video frames into an AXI4-Stream with SOF/EOL marks
module vid_to_axis_packer import vid_axis_pkg::*; #(
   parameter int FIFO_DEPTH = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PIX_W-1:0]     vid_pData_i,
   input  logic                 vid_pHSync_i,
   input  logic                 vid_pVSync_i,
   input  logic                 vid_pVDE_i,
   input  logic                 enable,
   input  logic                 clear_status,
   vid_to_axis_packer_if.master m_axis,
   output logic                 overflow,
   output logic [15:0]          drop_count,
   output logic [15:0]          frame_count
);
   cap_state_t       state, state_n;
   logic             vs_d1, fs, vs_rise;
   logic             take_fs, cap;
   logic             sof_pending, hold_v, hold_sof;
   logic [PIX_W-1:0] hold_pix;
   entry_t           din_e, dout_e;
   logic             fifo_empty, fifo_drop;
   logic             unused_hsync;
   assign unused_hsync = vid_pHSync_i;
   assign fs      = vs_d1 & ~vid_pVSync_i;
   assign vs_rise = ~vs_d1 & vid_pVSync_i;
   // state and vsync history
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         vs_d1 <= 1'b0;
      end else begin
         state <= state_n;
         vs_d1 <= vid_pVSync_i;
      end
   end
   // next state; a frame start seen in WAIT_SOF opens capture in that same cycle
   always_comb begin
      state_n = state;
      take_fs = 1'b0;
      cap     = 1'b0;
      unique case (state)
         IDLE:     state_n = enable ? WAIT_SOF : IDLE;
         WAIT_SOF: begin
            state_n = !enable ? IDLE : (fs ? ACTIVE : WAIT_SOF);
            take_fs = enable & fs;
            cap     = enable & fs & vid_pVDE_i;
         end
         ACTIVE:   begin
            state_n = (!enable && vs_rise) ? IDLE : ACTIVE;
            take_fs = fs;
            cap     = vid_pVDE_i;
         end
         default:  state_n = IDLE;
      endcase
   end
   // one-pixel hold so the held entry learns whether it ends the line
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_v      <= 1'b0;
         hold_sof    <= 1'b0;
         hold_pix    <= '0;
         sof_pending <= 1'b0;
      end else begin
         hold_v      <= cap;
         hold_sof    <= cap ? (sof_pending | take_fs) : hold_sof;
         hold_pix    <= cap ? vid_pData_i : hold_pix;
         sof_pending <= cap ? 1'b0 : (take_fs ? 1'b1 : (state_n == IDLE ? 1'b0 : sof_pending));
      end
   end
   assign din_e = {hold_sof, ~cap, hold_pix};
   sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (hold_v),
      .din   (din_e),
      .pop   (m_axis.tvalid & m_axis.tready),
      .dout  (dout_e),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );
   assign m_axis.tvalid = ~fifo_empty;
   assign m_axis.tdata  = {8'h00, dout_e.pix};
   assign m_axis.tlast  = dout_e.last;
   assign m_axis.tuser  = dout_e.sof;
   // sticky drop status with clear taking priority, and the frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow    <= 1'b0;
         drop_count  <= '0;
         frame_count <= '0;
      end else begin
         overflow    <= clear_status ? 1'b0 : (overflow | fifo_drop);
         drop_count  <= clear_status ? '0 : ((fifo_drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count);
         frame_count <= take_fs ? frame_count + 16'd1 : frame_count;
      end
   end
endmodule

// File: tb/tb_vid_to_axis_packer.sv
// tb_vid_to_axis_packer: directed and randomized frames checked against a frame/line-level beat model
module tb_vid_to_axis_packer;
   logic        clk = 1'b0;
   logic        reset, enable, clear_status;
   logic [23:0] vid_pData_i;
   logic        vid_pHSync_i, vid_pVSync_i, vid_pVDE_i;
   logic        overflow;
   logic [15:0] drop_count, frame_count;
   vid_to_axis_packer_if axis();

   vid_to_axis_packer #(.FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .vid_pData_i  (vid_pData_i),
      .vid_pHSync_i (vid_pHSync_i),
      .vid_pVSync_i (vid_pVSync_i),
      .vid_pVDE_i   (vid_pVDE_i),
      .enable       (enable),
      .clear_status (clear_status),
      .m_axis       (axis),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .frame_count  (frame_count)
   );

   always #5 clk = ~clk;

   int          vecs = 0;
   int          errs = 0;
   int          rdy_mode = 0;
   logic [33:0] exp_q [$];
   logic [33:0] beat, prev_beat;
   logic        prev_stall = 1'b0;
   logic [23:0] pix_ctr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      vecs++;
      assert (got === want) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic cyc(input logic vde, input logic vs, input logic [23:0] d);
      vid_pVDE_i   = vde;
      vid_pVSync_i = vs;
      vid_pData_i  = d;
      vid_pHSync_i = vde;
      axis.tready  = (rdy_mode == 2) ? ($urandom_range(3, 0) != 0) : (rdy_mode == 1);
      @(negedge clk);
      beat = {axis.tuser, axis.tlast, axis.tdata};
      if (prev_stall) begin
         chk("stall_valid", axis.tvalid, 1);
         chk("stall_beat", beat, prev_beat);
      end
      if (axis.tvalid === 1'b1 && axis.tready) begin
         if (exp_q.size() == 0) chk("unexpected_beat_queue_size", exp_q.size(), 1);
         else chk("beat", beat, exp_q.pop_front());
      end
      prev_stall = (axis.tvalid === 1'b1) & ~axis.tready & ~reset;
      prev_beat  = beat;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input int nl, input int np, input bit rnd, input int gap, input bit on, input int en_off);
      logic [23:0] d;
      int n;
      cyc(0, 1, 0);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      for (int l = 0; l < nl; l++) begin
         if (l == en_off) enable = 1'b0;
         n = rnd ? int'($urandom_range(np, 1)) : np;
         for (int p = 0; p < n; p++) begin
            d = rnd ? 24'($urandom()) : pix_ctr;
            pix_ctr++;
            if (on) exp_q.push_back({l == 0 && p == 0, p == n - 1, 8'h00, d});
            cyc(1, 0, d);
         end
         repeat (gap) cyc(0, 0, 0);
      end
   endtask

   task automatic drain(input int n);
      repeat (n) cyc(0, 0, 0);
      chk("drain_queue_empty", exp_q.size(), 0);
      chk("drain_tvalid", axis.tvalid, 0);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      repeat (2) cyc(0, 0, 0);
      reset = 1'b0;
   endtask

   task automatic chk_reset_state;
      chk("rst_tvalid", axis.tvalid, 0);
      chk("rst_tdata", axis.tdata, 0);
      chk("rst_tlast", axis.tlast, 0);
      chk("rst_tuser", axis.tuser, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_frame_count", frame_count, 0);
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      clear_status = 1'b0;
      axis.tready = 1'b0;
      vid_pData_i = '0;
      vid_pHSync_i = 1'b0;
      vid_pVSync_i = 1'b0;
      vid_pVDE_i = 1'b0;
      do_reset();
      chk_reset_state();

      enable = 1'b1;
      rdy_mode = 1;
      pix_ctr = 24'd1;
      frame(4, 3, 0, 1, 1, -1);
      drain(10);
      chk("burst_frame_count", frame_count, 1);
      chk("burst_overflow", overflow, 0);

      rdy_mode = 0;
      pix_ctr = 24'd1;
      frame(1, 8, 0, 3, 0, -1);
      chk("bp_drop_count", drop_count, 4);
      chk("bp_overflow", overflow, 1);
      chk("bp_tvalid", axis.tvalid, 1);
      for (int i = 1; i <= 4; i++) exp_q.push_back({i == 1, 1'b0, 8'h00, 24'(i)});
      rdy_mode = 1;
      drain(10);
      clear_status = 1'b1;
      cyc(0, 0, 0);
      clear_status = 1'b0;
      chk("clr_overflow", overflow, 0);
      chk("clr_drop_count", drop_count, 0);

      pix_ctr = 24'h100;
      frame(3, 1, 0, 1, 1, -1);
      frame(2, 1, 0, 1, 1, -1);
      drain(10);

      rdy_mode = 2;
      for (int f = 0; f < 3; f++) frame(4, 4, 1, 16, 1, -1);
      drain(40);
      chk("stall_drop_count", drop_count, 0);

      rdy_mode = 0;
      cyc(0, 1, 0);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 24'hA0 + 24'(i));
      chk("pre_reset_tvalid", axis.tvalid, 1);
      reset = 1'b1;
      cyc(0, 0, 0);
      reset = 1'b0;
      chk_reset_state();
      exp_q.delete();
      rdy_mode = 1;
      pix_ctr = 24'h200;
      frame(1, 2, 0, 2, 1, -1);
      drain(10);
      chk("post_reset_frame_count", frame_count, 1);

      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1, 0, 24'hBB0 + 24'(i));
      chk("prefs_tvalid", axis.tvalid, 0);
      pix_ctr = 24'h300;
      frame(3, 3, 0, 2, 1, 1);
      frame(2, 3, 0, 2, 0, -1);
      drain(10);
      chk("midframe_frame_count", frame_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
